// File: rtl/lock_pkg.sv
// Shared definitions for the canal-lock chamber controller.
//   - lock_state_e  : 3-bit FSM state codes (also driven out on the state port)
//   - lock_out_t    : gate/pump/busy output bundle
//   - decode_outputs: Moore decode of (state, side) into lock_out_t
//   - default widths and phase durations in seconds
package lock_pkg;

    localparam int W_DEFAULT       = 10;
    localparam int T_ENTER_DEFAULT = 300;
    localparam int T_FILL_DEFAULT  = 420;
    localparam int T_DRAIN_DEFAULT = 480;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREP     = 3'd1,
        ST_ENTER    = 3'd2,
        ST_EQUALIZE = 3'd3,
        ST_EXIT     = 3'd4
    } lock_state_e;

    typedef struct packed {
        logic gate_lo;
        logic gate_hi;
        logic fill;
        logic drain;
        logic busy;
    } lock_out_t;

    // side: 0 = low side, 1 = high side.
    // A gate is only ever open in ENTER/EXIT and a pump only in PREP/EQUALIZE,
    // so gates and pumps are mutually exclusive by construction.
    function automatic lock_out_t decode_outputs(lock_state_e s, logic sd);
        lock_out_t o;
        o         = '0;
        o.busy    = (s != ST_IDLE);
        o.gate_lo = ((s == ST_ENTER) && !sd) || ((s == ST_EXIT) && sd);
        o.gate_hi = ((s == ST_ENTER) && sd)  || ((s == ST_EXIT) && !sd);
        o.fill    = ((s == ST_PREP) && sd)   || ((s == ST_EQUALIZE) && !sd);
        o.drain   = ((s == ST_PREP) && !sd)  || ((s == ST_EQUALIZE) && sd);
        return o;
    endfunction

    function automatic logic is_timed(lock_state_e s);
        return (s == ST_PREP) || (s == ST_ENTER) || (s == ST_EQUALIZE);
    endfunction

endpackage

// File: rtl/countdown_timer.sv
// Seconds countdown used to time each chamber phase.
// Ports:
//   clk, reset (async, active low)
//   load, load_val[W] : load a new duration (wins over decrement)
//   tick              : decrement by one when set; saturates at 0
//   value[W], zero    : current count and value == 0
module countdown_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic [W-1:0] value,
    output logic         zero
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (tick && (value != '0)) begin
            value <= value - W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/lock_cycle_ctrl.sv
// Canal-lock chamber sequencer and low/high side arbiter.
// Ports:
//   clk, reset (async, active low), tick (1 Hz strobe)
//   arrive_lo / arrive_hi : boat waiting pulses; boat_clear : boat left chamber
//   gate_lo, gate_hi, fill, drain : actuator enables (registered)
//   busy : not IDLE; side : side being served (held in IDLE)
//   remaining[W] : seconds left in the current timed phase
//   state[3] : current FSM state code (debug / display)
// Cycle: IDLE -> (PREP if the level is wrong) -> ENTER -> EQUALIZE -> EXIT -> IDLE.
module lock_cycle_ctrl
    import lock_pkg::*;
#(
    parameter int W       = W_DEFAULT,
    parameter int T_ENTER = T_ENTER_DEFAULT,
    parameter int T_FILL  = T_FILL_DEFAULT,
    parameter int T_DRAIN = T_DRAIN_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         arrive_lo,
    input  logic         arrive_hi,
    input  logic         boat_clear,
    output logic         gate_lo,
    output logic         gate_hi,
    output logic         fill,
    output logic         drain,
    output logic         busy,
    output logic         side,
    output logic [W-1:0] remaining,
    output logic [2:0]   state
);

    lock_state_e st_q, nxt_state;
    logic        side_q, nxt_side;
    logic        last_served, nxt_last;
    logic        water_high, nxt_wh;
    logic        pend_lo, pend_hi;
    logic        grant_lo, grant_hi;
    logic        load;
    logic [W-1:0] load_val;
    logic        t_zero;
    logic [W-1:0] t_value;
    lock_out_t   out_q;

    // tick only counts while a timed phase is running.
    countdown_timer #(.W(W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .tick     (tick && is_timed(st_q)),
        .value    (t_value),
        .zero     (t_zero)
    );

    always_comb begin
        nxt_state = st_q;
        nxt_side  = side_q;
        nxt_last  = last_served;
        nxt_wh    = water_high;
        grant_lo  = 1'b0;
        grant_hi  = 1'b0;
        load      = 1'b0;
        load_val  = '0;
        unique case (st_q)
            ST_IDLE: begin
                if (pend_lo || pend_hi) begin
                    // hi wins only if lo is absent or lo was served last.
                    nxt_side = pend_hi && (!pend_lo || !last_served);
                    nxt_last = nxt_side;
                    grant_lo = !nxt_side;
                    grant_hi = nxt_side;
                    load     = 1'b1;
                    if (water_high == nxt_side) begin
                        nxt_state = ST_ENTER;
                        load_val  = W'(T_ENTER);
                    end else begin
                        nxt_state = ST_PREP;
                        load_val  = nxt_side ? W'(T_FILL) : W'(T_DRAIN);
                    end
                end
            end
            ST_PREP: begin
                if (t_zero) begin
                    nxt_wh    = side_q;
                    nxt_state = ST_ENTER;
                    load      = 1'b1;
                    load_val  = W'(T_ENTER);
                end
            end
            ST_ENTER: begin
                if (t_zero) begin
                    nxt_state = ST_EQUALIZE;
                    load      = 1'b1;
                    load_val  = side_q ? W'(T_DRAIN) : W'(T_FILL);
                end
            end
            ST_EQUALIZE: begin
                // Timer is already 0 on exit, so EXIT shows remaining = 0.
                if (t_zero) begin
                    nxt_wh    = !water_high;
                    nxt_state = ST_EXIT;
                end
            end
            ST_EXIT: begin
                if (boat_clear) nxt_state = ST_IDLE;
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Actuator outputs are decoded from the next state so they change on the
    // same edge as the state register, with no combinational path to the pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q        <= ST_IDLE;
            side_q      <= 1'b0;
            last_served <= 1'b1;
            water_high  <= 1'b0;
            pend_lo     <= 1'b0;
            pend_hi     <= 1'b0;
            out_q       <= '0;
        end else begin
            st_q        <= nxt_state;
            side_q      <= nxt_side;
            last_served <= nxt_last;
            water_high  <= nxt_wh;
            // A grant clears the request even if a new pulse lands on that edge.
            pend_lo     <= (pend_lo || arrive_lo) && !grant_lo;
            pend_hi     <= (pend_hi || arrive_hi) && !grant_hi;
            out_q       <= decode_outputs(nxt_state, nxt_side);
        end
    end

    assign gate_lo   = out_q.gate_lo;
    assign gate_hi   = out_q.gate_hi;
    assign fill      = out_q.fill;
    assign drain     = out_q.drain;
    assign busy      = out_q.busy;
    assign side      = side_q;
    assign remaining = t_value;
    assign state     = st_q;

endmodule

// File: doc/lock_cycle_ctrl.md
Name: lock_cycle_ctrl

Overview:
- Sequencer and arbiter for the canal-lock chamber, the shared resource.
- Accepts boat requests from the low side and the high side, and grants the chamber to one side at a time, round-robin on ties.
- Steps the chamber through level-adjust, enter, equalize and exit phases, timing each phase with an internal seconds countdown.
- Drives the gate and pump enables and exposes the remaining seconds for the display.

Parameters:
- W, 10: countdown width in bits; maximum 1023 s.
- T_ENTER, 300: enter dwell in seconds (5 min).
- T_FILL, 420: fill time in seconds (7 min).
- T_DRAIN, 480: drain time in seconds (8 min).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle 1 Hz strobe; the timer advances only when this is high.
- arrive_lo  in  1  pulse: a boat is waiting on the low side.
- arrive_hi  in  1  pulse: a boat is waiting on the high side.
- boat_clear  in  1  pulse: the boat has left the chamber.
- gate_lo  out  1  low gate open.
- gate_hi  out  1  high gate open.
- fill  out  1  fill pump on.
- drain  out  1  drain pump on.
- busy  out  1  state is not IDLE.
- side  out  1  side being served (0 = lo, 1 = hi); holds its last value in IDLE.
- remaining  out  W  seconds left in the current timed phase; 0 otherwise.
- state  out  3  current state code.

Behaviour:
- Reset (asynchronous, while reset = 0):
  - state = IDLE; all outputs 0.
  - water_high = 0; pend_lo = pend_hi = 0.
  - last_served = 1, so lo wins the first tie.
- Requests:
  - arrive_x sets pend_x on any clock edge, in any state.
  - A repeated pulse while pend_x is already set has no effect.
  - pend_x clears on the edge at which side x is granted.
- State codes: IDLE = 0, PREP = 1, ENTER = 2, EQUALIZE = 3, EXIT = 4.
- IDLE, no pending request: stay.
  - One pending side: grant it.
  - Both pending: grant the side that is not last_served.
  - On grant, latch side and set last_served = side.
  - If the water level already matches the side (lo ↔ water_high = 0, hi ↔ water_high = 1), go to ENTER. Otherwise go to PREP.
- PREP: pump toward the served side's level.
  - Side lo: drain, timer = T_DRAIN.
  - Side hi: fill, timer = T_FILL.
  - On expiry, update water_high to the new level and go to ENTER.
- ENTER: open the served side's gate; timer = T_ENTER. On expiry go to EQUALIZE.
- EQUALIZE: gates closed; pump to the opposite level.
  - Side lo: fill, T_FILL.
  - Side hi: drain, T_DRAIN.
  - On expiry, toggle water_high and go to EXIT.
- EXIT: open the opposite gate. On the boat_clear pulse go to IDLE. There is no timeout; remaining = 0.
- Timer rule:
  - Loaded with the phase duration on the edge that enters a timed state.
  - Each subsequent cycle: if remaining = 0, take the exit transition on this edge; else if tick, decrement by 1.
  - With tick held high, a timed state lasts T + 1 cycles.
  - A duration of 0 leaves after 1 cycle.
  - The timer never wraps below 0.
- Outputs are a registered, Moore function of state, side and the timer.
- Invariants, which the verifier asserts every cycle:
  - gate_lo & gate_hi never both 1.
  - fill & drain never both 1.
  - No gate open while fill or drain is 1.
- boat_clear outside EXIT is ignored.
- tick is ignored in IDLE and EXIT.
- Reset asserted mid-cycle: immediately close the gates and stop the pumps. The level is forgotten (water_high = 0) and pending requests are dropped.

Decomposition:
- Package lock_pkg holds:
  - the state enum (3-bit codes above);
  - the default durations 300, 420 and 480;
  - W_DEFAULT = 10.
- Sub-module countdown_timer, same clk/reset:
  - inputs load, load_val[W], tick;
  - outputs value[W], zero;
  - behaviour: load has priority over decrement; saturates at 0.
- FSM, arbitration and output decode stay in lock_cycle_ctrl.

Test Plan (tick held at 1 unless stated):
- Reset, then arrive_lo → IDLE → ENTER (level already low) → gate_lo = 1 for 301 cycles, with remaining counting 300 → 0. Then EQUALIZE with fill = 1 for 421 cycles, then EXIT with gate_hi = 1. boat_clear → IDLE, water_high = 1.
- From water_high = 1, arrive_lo → PREP with drain = 1 and remaining = 480, lasting 481 cycles → ENTER with gate_lo.
- arrive_lo and arrive_hi pulsed on the same edge after reset → lo is served first, pend_hi stays 1. After boat_clear, hi is served next without a new pulse. On the next simultaneous tie, lo wins.
- tick pulsed every 4th cycle in ENTER → remaining decrements once per tick, and ENTER holds 4×300 + 1 cycles within ±3.
- reset driven low mid-EQUALIZE, asynchronously between edges → gates, pumps, busy and remaining read 0 before the next edge. After release, the block is in IDLE with water_high = 0.
- Throughout all runs, the invariant assertions hold. boat_clear pulsed in ENTER has no effect, and tick = 0 in ENTER freezes remaining.
